// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: ID load-use detection, a counter-driven freeze FSM for
// multi-cycle MEM loads and EX mul/div, branch-flush gating and a saturating stall counter.
module hazard_ctrl_unit #(
    parameter int unsigned MEM_WAIT   = 2,
    parameter int unsigned MULDIV_LAT = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned STAT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [4:0]        reg_rs1_addr_i,
    input  logic [4:0]        reg_rs2_addr_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic [4:0]        id_ex_reg_wr_addr_i,
    input  logic              id_ex_reg_wr_sig_i,
    input  logic [1:0]        id_ex_data_dest_i,
    input  logic              id_ex_muldiv_i,
    input  logic              mem_load_i,
    input  logic              branch_taken_i,
    output logic              stall_o,
    output logic              id_ex_stall_o,
    output logic              mem_stall_o,
    output logic              bubble_o,
    output logic              ex_bubble_o,
    output logic              flush_o,
    output logic              busy_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    // Shared write-back source code: 0 = ALU result, 1 = load data from MEM.
    localparam logic [1:0] DEST_MEM = 2'd1;

    localparam bit MEM_EN    = (MEM_WAIT > 0);
    localparam bit MD_EN     = (MULDIV_LAT > 0);
    localparam bit MEM_MULTI = (MEM_WAIT > 1);
    localparam bit MD_MULTI  = (MULDIV_LAT > 1);

    localparam logic [CNT_W-1:0] MEM_INIT = CNT_W'(MEM_EN ? MEM_WAIT - 1 : 0);
    localparam logic [CNT_W-1:0] MD_INIT  = CNT_W'(MD_EN ? MULDIV_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] MD_LOAD  = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_BUSY = 2'd1,
        S_MD_BUSY  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [STAT_W-1:0]   r_stall_cnt;

    logic w_lu_raw;
    logic w_mem_trig;
    logic w_md_trig;
    logic w_open;
    logic w_flush;
    logic w_lu;

    logic w_stall;
    logic w_id_ex_stall;
    logic w_mem_stall;
    logic w_bubble;
    logic w_ex_bubble;
    logic w_flush_out;
    logic w_busy;

    assign w_lu_raw = id_ex_reg_wr_sig_i
                    & (id_ex_data_dest_i == DEST_MEM)
                    & (id_ex_reg_wr_addr_i != 5'd0)
                    & ((rs1_used_i & (id_ex_reg_wr_addr_i == reg_rs1_addr_i))
                     | (rs2_used_i & (id_ex_reg_wr_addr_i == reg_rs2_addr_i)));

    // The older MEM instruction wins over a mul/div sitting behind it in EX.
    assign w_mem_trig = (r_state == S_IDLE) & MEM_EN & mem_load_i;
    assign w_md_trig  = (r_state == S_IDLE) & MD_EN & id_ex_muldiv_i & ~w_mem_trig;

    // A freeze starting this cycle holds a taken branch in EX; it flushes after release.
    assign w_open  = ((r_state == S_IDLE) & ~w_mem_trig & ~w_md_trig) | (r_state == S_RELEASE);
    assign w_flush = w_open & branch_taken_i;
    assign w_lu    = w_open & w_lu_raw & ~w_flush;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_mem_trig) begin
                    w_cnt_nxt = MEM_INIT;
                    if (MEM_MULTI) begin
                        w_state_nxt = S_MEM_BUSY;
                    end else if (MD_EN && id_ex_muldiv_i) begin
                        w_state_nxt = S_MD_BUSY;
                        w_cnt_nxt   = MD_LOAD;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end else if (w_md_trig) begin
                    w_cnt_nxt   = MD_INIT;
                    w_state_nxt = MD_MULTI ? S_MD_BUSY : S_RELEASE;
                end
            end
            S_MEM_BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    if (MD_EN && id_ex_muldiv_i) begin
                        w_state_nxt = S_MD_BUSY;
                        w_cnt_nxt   = MD_LOAD;
                    end else begin
                        w_state_nxt = S_RELEASE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_MD_BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_stall       = 1'b0;
        w_id_ex_stall = 1'b0;
        w_mem_stall   = 1'b0;
        w_bubble      = 1'b0;
        w_ex_bubble   = 1'b0;
        w_flush_out   = 1'b0;
        w_busy        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem_trig) begin
                    w_stall       = 1'b1;
                    w_id_ex_stall = 1'b1;
                    w_mem_stall   = 1'b1;
                end else if (w_md_trig) begin
                    w_stall       = 1'b1;
                    w_id_ex_stall = 1'b1;
                    w_ex_bubble   = 1'b1;
                end else begin
                    w_flush_out = w_flush;
                    w_stall     = w_lu;
                    w_bubble    = w_lu;
                end
            end
            S_MEM_BUSY: begin
                w_stall       = 1'b1;
                w_id_ex_stall = 1'b1;
                w_mem_stall   = 1'b1;
                w_busy        = 1'b1;
            end
            S_MD_BUSY: begin
                w_stall       = 1'b1;
                w_id_ex_stall = 1'b1;
                w_ex_bubble   = 1'b1;
                w_busy        = 1'b1;
            end
            S_RELEASE: begin
                w_flush_out = w_flush;
                w_stall     = w_lu;
                w_bubble    = w_lu;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        // Combinational outputs are held low for as long as reset is asserted.
        if (!rst_n_i) begin
            w_stall       = 1'b0;
            w_id_ex_stall = 1'b0;
            w_mem_stall   = 1'b0;
            w_bubble      = 1'b0;
            w_ex_bubble   = 1'b0;
            w_flush_out   = 1'b0;
            w_busy        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

    assign stall_o       = w_stall;
    assign id_ex_stall_o = w_id_ex_stall;
    assign mem_stall_o   = w_mem_stall;
    assign bubble_o      = w_bubble;
    assign ex_bubble_o   = w_ex_bubble;
    assign flush_o       = w_flush_out;
    assign busy_o        = w_busy;
    assign stall_cnt_o   = r_stall_cnt;

    a_busy_stalls: assert property (@(posedge clk_i) disable iff (!rst_n_i) w_busy |-> w_stall);
    a_flush_no_stall: assert property (@(posedge clk_i) disable iff (!rst_n_i) w_flush_out |-> !w_stall);
    a_busy_cnt_live: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ((r_state == S_MEM_BUSY) || (r_state == S_MD_BUSY)) |-> (r_cnt != '0));

endmodule
